md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 120 ++++++++++++
 tb/tb_md_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// Multiply/divide unit controller for the E stage: runs a fixed-latency
// mult/div, owns the architectural HI/LO registers and raises the D-stage stall.
//
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   E_md_op     - E-stage op: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   E_A, E_B    - forwarded rs/rt operands in E
//   D_md_use    - D-stage instruction touches the mult/div unit or HI/LO
//   E_busy      - unit is computing
//   E_HI, E_LO  - architectural HI/LO registers
//   stall_md    - hold F/D and bubble D/E
module md_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    output logic        E_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic        stall_md
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    logic [3:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        is_div;
    logic        is_signed;
    logic        start_op;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign start_op = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU);
    assign E_busy   = (cnt != 4'd0);
    assign stall_md = D_md_use & (E_busy | start_op);

    // Results are formed from the captured operands and only committed on
    // the final busy edge, so HI/LO stay architecturally stable meanwhile.
    always_comb begin
        ext_a = {{32{is_signed & op_a[31]}}, op_a};
        ext_b = {{32{is_signed & op_b[31]}}, op_b};
        prod  = ext_a * ext_b;

        // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow
        // trap and gives truncation toward zero with the dividend's sign
        // on the remainder.
        neg_a = is_signed & op_a[31];
        neg_b = is_signed & op_b[31];
        mag_a = neg_a ? (32'd0 - op_a) : op_a;
        mag_b = neg_b ? (32'd0 - op_b) : op_b;
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (mag_b != 32'd0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quot = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem  = neg_a ? (32'd0 - r_mag) : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            E_HI      <= 32'd0;
            E_LO      <= 32'd0;
        end else if (E_busy) begin
            // Any new op while busy is dropped.
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                if (!is_div) begin
                    E_HI <= prod[63:32];
                    E_LO <= prod[31:0];
                end else if (op_b != 32'd0) begin
                    E_HI <= rem;
                    E_LO <= quot;
                end
            end
        end else begin
            unique case (E_md_op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    op_a      <= E_A;
                    op_b      <= E_B;
                    is_div    <= (E_md_op == OP_DIV) || (E_md_op == OP_DIVU);
                    is_signed <= (E_md_op == OP_MULT) || (E_md_op == OP_DIV);
                    cnt       <= ((E_md_op == OP_MULT) || (E_md_op == OP_MULTU))
                                 ? MULT_CYCLES : DIV_CYCLES;
                end
                OP_MTHI: E_HI <= E_A;
                OP_MTLO: E_LO <= E_A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl: mult/div results and latency,
// HI/LO moves, stall behaviour, ignored ops while busy and reset abort.
module tb_md_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  E_md_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_md_use;
    logic        E_busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
    logic        stall_md;

    int n_checks = 0;
    int n_fail   = 0;

    md_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .E_md_op  (E_md_op),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_md_use (D_md_use),
        .E_busy   (E_busy),
        .E_HI     (E_HI),
        .E_LO     (E_LO),
        .stall_md (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one edge, then count busy cycles (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc);
        E_md_op = op;
        E_A     = a;
        E_B     = b;
        tick();
        E_md_op = 3'd0;
        cyc = 0;
        while (E_busy && cyc < 20) begin
            cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        E_md_op  = 3'd1;
        E_A      = 32'h1234;
        E_B      = 32'h5678;
        D_md_use = 1'b1;
        #1;
        n_checks++;
        if (E_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", E_busy);
        end
        n_checks++;
        if (E_HI !== 32'd0 || E_LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hilo got %h/%h want 0/0", E_HI, E_LO);
        end
        n_checks++;
        if (stall_md !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall got %b want 1", stall_md);
        end
        E_md_op  = 3'd0;
        D_md_use = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_mult();
        int cyc;
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, cyc);
        n_checks++;
        if (cyc !== 5) begin
            n_fail++;
            $display("FAIL mult_busy got %0d want 5", cyc);
        end
        n_checks++;
        if (E_HI !== 32'hFFFFFFFF || E_LO !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL mult_res got %h/%h want ffffffff/fffffffa",
                     E_HI, E_LO);
        end
    endtask

    task automatic test_multu();
        int cyc;
        run_op(3'd2, 32'hFFFFFFFE, 32'd3, cyc);
        n_checks++;
        if (cyc !== 5) begin
            n_fail++;
            $display("FAIL multu_busy got %0d want 5", cyc);
        end
        n_checks++;
        if (E_HI !== 32'h2 || E_LO !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL multu_res got %h/%h want 00000002/fffffffa",
                     E_HI, E_LO);
        end
    endtask

    task automatic test_div();
        int cyc;
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, cyc);
        n_checks++;
        if (cyc !== 10) begin
            n_fail++;
            $display("FAIL div_busy got %0d want 10", cyc);
        end
        n_checks++;
        if (E_HI !== 32'hFFFFFFFF || E_LO !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL div_res got %h/%h want ffffffff/fffffffd",
                     E_HI, E_LO);
        end
        run_op(3'd3, 32'd7, 32'hFFFFFFFE, cyc);
        n_checks++;
        if (E_HI !== 32'd1 || E_LO !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL div_negb got %h/%h want 00000001/fffffffd",
                     E_HI, E_LO);
        end
        run_op(3'd4, 32'd7, 32'd2, cyc);
        n_checks++;
        if (cyc !== 10) begin
            n_fail++;
            $display("FAIL divu_busy got %0d want 10", cyc);
        end
        n_checks++;
        if (E_HI !== 32'd1 || E_LO !== 32'd3) begin
            n_fail++;
            $display("FAIL divu_res got %h/%h want 00000001/00000003",
                     E_HI, E_LO);
        end
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, cyc);
        n_checks++;
        if (E_HI !== 32'd0 || E_LO !== 32'h80000000) begin
            n_fail++;
            $display("FAIL div_ovf got %h/%h want 00000000/80000000",
                     E_HI, E_LO);
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        E_md_op = 3'd5;
        E_A     = 32'h11;
        tick();
        n_checks++;
        if (E_busy !== 1'b0 || E_HI !== 32'h11) begin
            n_fail++;
            $display("FAIL mthi got busy=%b hi=%h want 0/00000011",
                     E_busy, E_HI);
        end
        E_md_op = 3'd6;
        E_A     = 32'h22;
        tick();
        n_checks++;
        if (E_busy !== 1'b0 || E_LO !== 32'h22) begin
            n_fail++;
            $display("FAIL mtlo got busy=%b lo=%h want 0/00000022",
                     E_busy, E_LO);
        end
        run_op(3'd4, 32'd5, 32'd0, cyc);
        n_checks++;
        if (cyc !== 10) begin
            n_fail++;
            $display("FAIL divz_busy got %0d want 10", cyc);
        end
        n_checks++;
        if (E_HI !== 32'h11 || E_LO !== 32'h22) begin
            n_fail++;
            $display("FAIL divz_res got %h/%h want 00000011/00000022",
                     E_HI, E_LO);
        end
    endtask

    task automatic test_stall_ignore();
        int cyc;
        int bad;
        D_md_use = 1'b1;
        E_md_op  = 3'd1;
        E_A      = 32'd3;
        E_B      = 32'd4;
        #1;
        n_checks++;
        if (stall_md !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_start got %b want 1", stall_md);
        end
        tick();
        E_md_op = 3'd0;
        cyc = 0;
        bad = 0;
        while (E_busy && cyc < 20) begin
            cyc++;
            if (cyc == 3) begin
                E_md_op = 3'd6;
                E_A     = 32'hDEAD;
            end else begin
                E_md_op = 3'd0;
            end
            #1;
            if (stall_md !== 1'b1) bad++;
            tick();
        end
        E_md_op = 3'd0;
        #1;
        n_checks++;
        if (bad !== 0 || cyc !== 5) begin
            n_fail++;
            $display("FAIL stall_busy got bad=%0d cyc=%0d want 0/5", bad, cyc);
        end
        n_checks++;
        if (stall_md !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end got %b want 0", stall_md);
        end
        n_checks++;
        if (E_HI !== 32'd0 || E_LO !== 32'd12) begin
            n_fail++;
            $display("FAIL ignore_mtlo got %h/%h want 00000000/0000000c",
                     E_HI, E_LO);
        end
        D_md_use = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(3'd2, 32'd5, 32'd6, cyc);
        E_md_op = 3'd2;
        E_A     = 32'd7;
        E_B     = 32'd8;
        tick();
        E_md_op = 3'd0;
        n_checks++;
        if (E_busy !== 1'b1 || E_LO !== 32'd30) begin
            n_fail++;
            $display("FAIL b2b_start got busy=%b lo=%h want 1/0000001e",
                     E_busy, E_LO);
        end
        cyc = 0;
        while (E_busy && cyc < 20) begin
            cyc++;
            tick();
        end
        n_checks++;
        if (cyc !== 5 || E_LO !== 32'd56) begin
            n_fail++;
            $display("FAIL b2b_res got cyc=%0d lo=%h want 5/00000038",
                     cyc, E_LO);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        int bad;
        E_md_op = 3'd3;
        E_A     = 32'd100;
        E_B     = 32'd7;
        tick();
        E_md_op = 3'd0;
        repeat (3) tick();
        reset    = 1'b1;
        D_md_use = 1'b1;
        #1;
        n_checks++;
        if (E_busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid got busy=%b hi=%h lo=%h want 0/0/0",
                     E_busy, E_HI, E_LO);
        end
        n_checks++;
        if (stall_md !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_stall got %b want 0", stall_md);
        end
        D_md_use = 1'b0;
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (E_busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rst_no_update got %0d bad cycles want 0", bad);
        end
        // first edge after release accepts a start
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        E_md_op = 3'd1;
        E_A     = 32'd2;
        E_B     = 32'd3;
        tick();
        E_md_op = 3'd0;
        n_checks++;
        if (E_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_first_start got busy=%b want 1", E_busy);
        end
        cyc = 0;
        while (E_busy && cyc < 20) begin
            cyc++;
            tick();
        end
        n_checks++;
        if (E_LO !== 32'd6 || E_HI !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_first_res got %h/%h want 00000000/00000006",
                     E_HI, E_LO);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_stall_ignore();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
